// File: rtl/concat_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// concat_scheduler_pkg
// Shared definitions for the channel-concatenation schedulers:
//   - sched_state_t : FSM state encoding (IDLE, one state per source, DRAIN)
//   - SRC_*         : src_sel codes (0 = none, k = source k)
//   - src_code()    : maps a state to its src_sel code
//   - next_src()    : picks the next non-empty source after a given one
// -----------------------------------------------------------------------------
package concat_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_S1    = 3'd1,
    ST_S2    = 3'd2,
    ST_S3    = 3'd3,
    ST_DRAIN = 3'd4
  } sched_state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_1    = 2'd1;
  localparam logic [1:0] SRC_2    = 2'd2;
  localparam logic [1:0] SRC_3    = 2'd3;

  // DRAIN reports the last source so the tail of the frame stays attributed.
  function automatic logic [1:0] src_code(input sched_state_t s);
    case (s)
      ST_S1:             return SRC_1;
      ST_S2:             return SRC_2;
      ST_S3, ST_DRAIN:   return SRC_3;
      default:           return SRC_NONE;
    endcase
  endfunction

  // First source after 'cur' whose pixel count is non-zero (nz[k-1] set for
  // source k); ST_DRAIN when no such source remains. Later assignments win,
  // so checking from source 3 down leaves the lowest eligible source.
  function automatic sched_state_t next_src(input logic [1:0] cur,
                                            input logic [2:0] nz);
    sched_state_t r;
    r = ST_DRAIN;
    if (cur < SRC_3 && nz[2]) r = ST_S3;
    if (cur < SRC_2 && nz[1]) r = ST_S2;
    if (cur < SRC_1 && nz[0]) r = ST_S1;
    return r;
  endfunction

endpackage

// File: rtl/concat_scheduler_pipe_reg_rdy.sv
// -----------------------------------------------------------------------------
// pipe_reg_rdy
// Single-entry valid/ready output register.
//   clk, reset      : clock, asynchronous active-high reset
//   load            : write load_data/load_last this cycle (honoured only
//                     when load_en is high)
//   load_data/last  : payload and end-of-frame marker to capture
//   load_en         : register can take a new word (empty or being drained)
//   out_valid/data  : registered word presented downstream
//   out_last        : marker travelling with out_data
//   out_ready       : downstream accepts the current word
// -----------------------------------------------------------------------------
module pipe_reg_rdy #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_en,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  // Combinational so the upstream ready drops in the same cycle a stall hits.
  assign load_en = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load && load_en) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (out_ready) begin
      // Data is left in place; only the qualifiers clear once drained.
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/concat_scheduler.sv
// -----------------------------------------------------------------------------
// concat_scheduler
// Merges three feature-map streams into one channel-concatenated stream by
// granting source 1, then 2, then 3 for D*D*C_k pixels each, without frame
// buffering. Sources with C_k = 0 are skipped.
//   clk, reset             : clock, asynchronous active-high reset
//   start                  : one-cycle pulse, begins a frame (IDLE only)
//   in_valid_k/in_data_k   : source k handshake and pixel
//   in_ready_k             : source k pixel accepted this cycle
//   out_valid/out_data     : registered output pixel
//   out_ready              : downstream accepts
//   out_last               : final pixel of the frame
//   src_sel                : 0 idle, k while serving source k, 3 in drain
//   busy                   : frame in progress
//   done                   : one-cycle pulse after the last pixel leaves
// -----------------------------------------------------------------------------
module concat_scheduler
  import concat_scheduler_pkg::*;
#(
  parameter int D          = 220,
  parameter int C_1        = 1,
  parameter int C_2        = 1,
  parameter int C_3        = 1,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(D * D * ((C_1 > C_2) ? ((C_1 > C_3) ? C_1 : C_3)
                                                         : ((C_2 > C_3) ? C_2 : C_3))) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid_1,
  input  logic [DATA_WIDTH-1:0] in_data_1,
  output logic                  in_ready_1,
  input  logic                  in_valid_2,
  input  logic [DATA_WIDTH-1:0] in_data_2,
  output logic                  in_ready_2,
  input  logic                  in_valid_3,
  input  logic [DATA_WIDTH-1:0] in_data_3,
  output logic                  in_ready_3,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [1:0]            src_sel,
  output logic                  busy,
  output logic                  done
);

  localparam longint T1 = longint'(D) * D * C_1;
  localparam longint T2 = longint'(D) * D * C_2;
  localparam longint T3 = longint'(D) * D * C_3;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  localparam logic [2:0] NZ = {T3 != 0, T2 != 0, T1 != 0};

  // Terminal counts; the value for an empty source is never compared.
  localparam logic [CNT_W-1:0] T1_LAST = CNT_W'(T1 - 1);
  localparam logic [CNT_W-1:0] T2_LAST = CNT_W'(T2 - 1);
  localparam logic [CNT_W-1:0] T3_LAST = CNT_W'(T3 - 1);

  if (T1 > CNT_MAX || T2 > CNT_MAX || T3 > CNT_MAX) begin : g_cnt_too_narrow
    $error("concat_scheduler: CNT_W too narrow for D*D*C_k");
  end

  sched_state_t          state, state_nxt;
  logic [CNT_W-1:0]      count;
  logic                  done_nxt;
  logic                  load_en;
  logic                  load_last;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CNT_W-1:0]      cur_last;
  logic                  xfer;
  logic                  end_of_src;
  sched_state_t          next_pick;

  // Source mux for the granted input.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    cur_last  = '0;
    case (state)
      ST_S1: begin sel_valid = in_valid_1; sel_data = in_data_1; cur_last = T1_LAST; end
      ST_S2: begin sel_valid = in_valid_2; sel_data = in_data_2; cur_last = T2_LAST; end
      ST_S3: begin sel_valid = in_valid_3; sel_data = in_data_3; cur_last = T3_LAST; end
      default: ;
    endcase
  end

  assign in_ready_1 = (state == ST_S1) && load_en;
  assign in_ready_2 = (state == ST_S2) && load_en;
  assign in_ready_3 = (state == ST_S3) && load_en;

  assign xfer       = sel_valid && load_en;
  assign end_of_src = xfer && (count == cur_last);
  assign next_pick  = next_src(src_code(state), NZ);
  assign src_sel    = src_code(state);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    load_last = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          // An empty frame completes immediately without leaving IDLE.
          if (next_pick == ST_DRAIN) done_nxt  = 1'b1;
          else                       state_nxt = next_pick;
        end
      end
      ST_S1, ST_S2, ST_S3: begin
        if (end_of_src) begin
          state_nxt = next_pick;
          load_last = (next_pick == ST_DRAIN);
        end
      end
      ST_DRAIN: begin
        if (out_valid && out_ready) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      // busy tracks the next state so it drops on the same edge as done rises.
      busy  <= (state_nxt != ST_IDLE);
      if (end_of_src)  count <= '0;
      else if (xfer)   count <= count + 1'b1;
    end
  end

  pipe_reg_rdy #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (xfer),
    .load_data (sel_data),
    .load_last (load_last),
    .load_en   (load_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_concat_scheduler.sv
// -----------------------------------------------------------------------------
// tb_concat_scheduler
// Three scheduler instances with D=2: A = C(1,2,1), B = C(1,0,1),
// Z = C(0,0,0). Sources always offer a pixel tagged {source, index}; the
// expected output order is derived from the per-source pixel counts.
// -----------------------------------------------------------------------------
module tb_concat_scheduler;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start     [3];
  logic          out_ready [3];
  logic          in_valid  [3][3];
  logic [DW-1:0] in_data   [3][3];
  logic          in_ready  [3][3];
  logic          out_valid [3];
  logic          out_last  [3];
  logic          busy      [3];
  logic          done      [3];
  logic [DW-1:0] out_data  [3];
  logic [1:0]    src_sel   [3];

  // Pixel counts per instance/source and frame totals.
  int tk  [3][3] = '{'{4, 8, 4}, '{4, 0, 4}, '{0, 0, 0}};
  int tot [3]    = '{16, 8, 0};

  int src_idx [3][3];
  logic hs    [3][3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    for (genvar gk = 0; gk < 3; gk++) begin : g_src
      assign in_data[gi][gk] = {8'(gk + 1), 24'(src_idx[gi][gk])};
    end
  end

  concat_scheduler #(.D(2), .C_1(1), .C_2(2), .C_3(1), .DATA_WIDTH(DW)) dut_a (
    .clk(clk), .reset(reset), .start(start[0]),
    .in_valid_1(in_valid[0][0]), .in_data_1(in_data[0][0]), .in_ready_1(in_ready[0][0]),
    .in_valid_2(in_valid[0][1]), .in_data_2(in_data[0][1]), .in_ready_2(in_ready[0][1]),
    .in_valid_3(in_valid[0][2]), .in_data_3(in_data[0][2]), .in_ready_3(in_ready[0][2]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0]), .src_sel(src_sel[0]), .busy(busy[0]), .done(done[0]));

  concat_scheduler #(.D(2), .C_1(1), .C_2(0), .C_3(1), .DATA_WIDTH(DW)) dut_b (
    .clk(clk), .reset(reset), .start(start[1]),
    .in_valid_1(in_valid[1][0]), .in_data_1(in_data[1][0]), .in_ready_1(in_ready[1][0]),
    .in_valid_2(in_valid[1][1]), .in_data_2(in_data[1][1]), .in_ready_2(in_ready[1][1]),
    .in_valid_3(in_valid[1][2]), .in_data_3(in_data[1][2]), .in_ready_3(in_ready[1][2]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1]), .src_sel(src_sel[1]), .busy(busy[1]), .done(done[1]));

  concat_scheduler #(.D(2), .C_1(0), .C_2(0), .C_3(0), .DATA_WIDTH(DW)) dut_z (
    .clk(clk), .reset(reset), .start(start[2]),
    .in_valid_1(in_valid[2][0]), .in_data_1(in_data[2][0]), .in_ready_1(in_ready[2][0]),
    .in_valid_2(in_valid[2][1]), .in_data_2(in_data[2][1]), .in_ready_2(in_ready[2][1]),
    .in_valid_3(in_valid[2][2]), .in_data_3(in_data[2][2]), .in_ready_3(in_ready[2][2]),
    .out_valid(out_valid[2]), .out_data(out_data[2]), .out_ready(out_ready[2]),
    .out_last(out_last[2]), .src_sel(src_sel[2]), .busy(busy[2]), .done(done[2]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-frame statistics gathered by the monitor inside tick().
  int            ncyc = 0;
  int            ocnt      [3];
  int            first_cyc [3];
  int            last_cyc  [3];
  int            done_cnt  [3];
  int            done_cyc  [3];
  int            busy_cyc  [3];
  logic          seen_valid[3];
  logic          seen_sel  [3][4];
  logic          hold      [3];
  logic [DW-1:0] hold_data [3];
  int            start_cyc;

  function automatic logic [DW-1:0] exp_pix(input int i, input int n);
    int r;
    r = n;
    if (r < tk[i][0]) return {8'd1, 24'(r)};
    r = r - tk[i][0];
    if (r < tk[i][1]) return {8'd2, 24'(r)};
    r = r - tk[i][1];
    return {8'd3, 24'(r)};
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < 3; i++) begin
      ocnt[i] = 0; first_cyc[i] = -1; last_cyc[i] = -1;
      done_cnt[i] = 0; done_cyc[i] = -1; busy_cyc[i] = 0;
      seen_valid[i] = 1'b0; hold[i] = 1'b0; hold_data[i] = '0;
      for (int s = 0; s < 4; s++) seen_sel[i][s] = 1'b0;
      for (int k = 0; k < 3; k++) src_idx[i][k] = 0;
    end
  endtask

  // Samples at the falling edge, then advances past the next rising edge.
  task automatic tick();
    logic ok;
    @(negedge clk);
    ncyc++;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        hs[i][k] = in_valid[i][k] && in_ready[i][k];
        if (in_ready[i][k]) begin
          // Only the current source may be ready: earlier ones finished,
          // later ones untouched, and src_sel names it.
          ok = (tk[i][k] > 0) && (src_idx[i][k] < tk[i][k]) && (src_sel[i] == 2'(k + 1));
          for (int j = 0; j < 3; j++) begin
            if (j < k && src_idx[i][j] != tk[i][j]) ok = 1'b0;
            if (j > k && src_idx[i][j] != 0)        ok = 1'b0;
          end
          check($sformatf("rdy_order_i%0d_s%0d", i, k + 1), ok, 1);
        end
      end
      if (hold[i]) begin
        check($sformatf("hold_valid_i%0d", i), out_valid[i], 1);
        check($sformatf("hold_data_i%0d", i), out_data[i], hold_data[i]);
      end
      hold[i]      = out_valid[i] && !out_ready[i];
      hold_data[i] = out_data[i];
      if (out_valid[i] && out_ready[i]) begin
        check($sformatf("pix_data_i%0d_n%0d", i, ocnt[i]), out_data[i], exp_pix(i, ocnt[i]));
        check($sformatf("pix_last_i%0d_n%0d", i, ocnt[i]), out_last[i], ocnt[i] == tot[i] - 1);
        if (ocnt[i] == 0) first_cyc[i] = ncyc;
        last_cyc[i] = ncyc;
        ocnt[i]++;
      end
      if (out_valid[i]) seen_valid[i] = 1'b1;
      if (busy[i])      busy_cyc[i]++;
      if (done[i]) begin
        done_cnt[i]++;
        done_cyc[i] = ncyc;
      end
      seen_sel[i][src_sel[i]] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++)
        if (hs[i][k]) src_idx[i][k]++;
  endtask

  // Runs one frame on instance i; optional out_ready toggling and a second
  // start pulse 'restart_at' cycles in (while busy).
  task automatic run_frame(input int i, input int budget, input bit toggle, input int restart_at);
    int n;
    clear_stats();
    start[i] = 1'b1;
    tick();
    start_cyc = ncyc;
    start[i] = 1'b0;
    n = 0;
    while (done_cnt[i] == 0 && n < budget) begin
      start[i] = (n == restart_at);
      tick();
      start[i] = 1'b0;
      if (toggle) out_ready[i] = !out_ready[i];
      n++;
    end
    out_ready[i] = 1'b1;
    if (done_cnt[i] == 0) check($sformatf("timeout_i%0d", i), 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      out_ready[i] = 1'b1;
      for (int k = 0; k < 3; k++) in_valid[i][k] = 1'b1;
    end
    clear_stats();

    // Reset state, observed before any clock edge.
    #3;
    check("rst_out_valid", out_valid[0], 0);
    check("rst_out_last",  out_last[0], 0);
    check("rst_out_data",  out_data[0], 0);
    check("rst_busy",      busy[0], 0);
    check("rst_done",      done[0], 0);
    check("rst_src_sel",   src_sel[0], 0);
    check("rst_in_ready",  {in_ready[0][0], in_ready[0][1], in_ready[0][2]}, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // A: full rate, all sources valid from the first cycle.
    run_frame(0, 60, 1'b0, -1);
    check("a1_count",      ocnt[0], 16);
    check("a1_first_cyc",  first_cyc[0], start_cyc + 2);
    check("a1_contiguous", last_cyc[0] - first_cyc[0], 15);
    check("a1_done_cyc",   done_cyc[0], last_cyc[0] + 1);
    check("a1_busy_cycles", busy_cyc[0], 17);
    check("a1_src_consumed", {8'(src_idx[0][0]), 8'(src_idx[0][1]), 8'(src_idx[0][2])}, {8'd4, 8'd8, 8'd4});
    tick(); tick();
    check("a1_done_once",  done_cnt[0], 1);

    // A: out_ready toggling every cycle.
    out_ready[0] = 1'b1;
    run_frame(0, 100, 1'b1, -1);
    check("a2_count",      ocnt[0], 16);
    check("a2_src_consumed", {8'(src_idx[0][0]), 8'(src_idx[0][1]), 8'(src_idx[0][2])}, {8'd4, 8'd8, 8'd4});
    check("a2_done_once",  done_cnt[0], 1);

    // B: source 2 skipped.
    run_frame(1, 60, 1'b0, -1);
    check("b_count",       ocnt[1], 8);
    check("b_sel1_seen",   seen_sel[1][1], 1);
    check("b_sel2_never",  seen_sel[1][2], 0);
    check("b_sel3_seen",   seen_sel[1][3], 1);
    check("b_src2_untouched", src_idx[1][1], 0);
    check("b_done_once",   done_cnt[1], 1);

    // Z: empty frame.
    run_frame(2, 10, 1'b0, -1);
    check("z_done_cyc",    done_cyc[2], start_cyc + 1);
    tick(); tick(); tick();
    check("z_done_once",   done_cnt[2], 1);
    check("z_no_valid",    seen_valid[2], 0);
    check("z_no_output",   ocnt[2], 0);

    // A: reset after 6 transfers, then a fresh frame with a stray start.
    begin
      int n;
      clear_stats();
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      n = 0;
      while (src_idx[0][0] + src_idx[0][1] < 6 && n < 30) begin
        tick();
        n++;
      end
      check("r_six_xfers", src_idx[0][0] + src_idx[0][1], 6);
      check("r_mid_busy",  busy[0], 1);
      #3 reset = 1'b1;
      #1;
      check("r_async_valid", out_valid[0], 0);
      check("r_async_busy",  busy[0], 0);
      check("r_async_sel",   src_sel[0], 0);
      check("r_async_rdy2",  in_ready[0][1], 0);
      tick(); tick();
      reset = 1'b0;
      tick(); tick(); tick();
      check("r_no_done",     done_cnt[0], 0);
    end
    run_frame(0, 60, 1'b0, 4);
    check("r2_count",      ocnt[0], 16);
    check("r2_first_cyc",  first_cyc[0], start_cyc + 2);
    repeat (5) tick();
    check("r2_done_once",  done_cnt[0], 1);
    check("r2_idle_busy",  busy[0], 0);
    check("r2_no_extra",   ocnt[0], 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
